// File: rtl/crypto_key_pkg.sv
`default_nettype none
//==============================================================================
// Module   : crypto_key_pkg
// Brief    : Shared types, defaults and helpers for the key reader slice.
// Revision : 1.0 - initial release
//==============================================================================
package crypto_key_pkg;

   localparam int c_key_w_default = 16;
   localparam int c_nib_w_default = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_XFER  = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   // Index width that stays at least one bit for single-entry tables.
   function automatic int slot_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_slot_bank.sv
`default_nettype none
//==============================================================================
// Module   : key_slot_bank
// Brief    : Key slot registers with valid flags and a write-forwarding read port.
// Revision : 1.0 - initial release
//==============================================================================
module key_slot_bank
   import crypto_key_pkg::*;
#(
   parameter  int NUM_SLOTS = 4,
   parameter  int KEY_W     = c_key_w_default,
   localparam int SLOT_W    = slot_idx_w(NUM_SLOTS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [KEY_W-1:0]  i_key,
   input  logic              i_load_en,
   input  logic [SLOT_W-1:0] i_load_slot,
   input  logic [SLOT_W-1:0] i_rd_slot,
   output logic [KEY_W-1:0]  o_rd_data,
   output logic              o_rd_valid
);

   logic [KEY_W-1:0] r_data  [NUM_SLOTS];
   logic             r_valid [NUM_SLOTS];
   logic             w_fwd;

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      always_ff @(posedge clk) begin
         if (reset) begin
            r_data[i]  <= '0;
            r_valid[i] <= 1'b0;
         end else if (i_load_en && (i_load_slot == SLOT_W'(i))) begin
            r_data[i]  <= i_key;
            r_valid[i] <= 1'b1;
         end
      end
   end

   // A load landing on the same edge as the read must win over the stored copy.
   assign w_fwd      = i_load_en && (i_load_slot == i_rd_slot);
   assign o_rd_data  = w_fwd ? i_key : r_data[i_rd_slot];
   assign o_rd_valid = w_fwd | r_valid[i_rd_slot];

endmodule
`default_nettype wire

// File: rtl/crypto_key_reader.sv
`default_nettype none
//==============================================================================
// Module   : crypto_key_reader
// Brief    : Checks a read request against slot validity and lock, then
//            streams a snapshot of the key MSB-first as NIB_W-bit beats.
// Revision : 1.0 - initial release
//==============================================================================
module crypto_key_reader
   import crypto_key_pkg::*;
#(
   parameter  int NUM_SLOTS = 4,
   parameter  int KEY_W     = c_key_w_default,
   parameter  int NIB_W     = c_nib_w_default,
   localparam int SLOT_W    = slot_idx_w(NUM_SLOTS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [KEY_W-1:0]  key_in,
   input  logic              key_load_en,
   input  logic [SLOT_W-1:0] key_load_slot,
   input  logic              lock_set,
   input  logic              rd_req,
   input  logic [SLOT_W-1:0] rd_slot,
   output logic              rd_busy,
   output logic [NIB_W-1:0]  nib_out,
   output logic              nib_valid,
   input  logic              nib_ready,
   output logic              nib_last,
   output logic              rd_done,
   output logic              rd_err
);

   localparam int c_BEATS = KEY_W / NIB_W;
   localparam int c_CNT_W = slot_idx_w(c_BEATS);

   state_t             r_state;
   logic [SLOT_W-1:0]  r_slot;
   logic [KEY_W-1:0]   r_snap;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_inc;
   logic               r_lock;
   logic [NIB_W-1:0]   r_nib_out;
   logic               r_nib_valid;
   logic               r_nib_last;
   logic               r_rd_done;
   logic               r_rd_err;
   logic               r_busy;
   logic [KEY_W-1:0]   w_slot_data;
   logic               w_slot_valid;

   key_slot_bank #(
      .NUM_SLOTS (NUM_SLOTS),
      .KEY_W     (KEY_W)
   ) u_bank (
      .clk         (clk),
      .reset       (reset),
      .i_key       (key_in),
      .i_load_en   (key_load_en),
      .i_load_slot (key_load_slot),
      .i_rd_slot   (r_slot),
      .o_rd_data   (w_slot_data),
      .o_rd_valid  (w_slot_valid)
   );

   function automatic logic [NIB_W-1:0] f_beat(input logic [KEY_W-1:0] v,
                                               input logic [c_CNT_W-1:0] idx);
      logic [KEY_W-1:0] shifted;
      shifted = v >> ((c_BEATS - 1 - int'(idx)) * NIB_W);
      return shifted[NIB_W-1:0];
   endfunction

   assign w_cnt_inc = r_cnt + c_CNT_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_slot      <= '0;
         r_snap      <= '0;
         r_cnt       <= '0;
         r_lock      <= 1'b0;
         r_nib_out   <= '0;
         r_nib_valid <= 1'b0;
         r_nib_last  <= 1'b0;
         r_rd_done   <= 1'b0;
         r_rd_err    <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_rd_done <= 1'b0;
         r_rd_err  <= 1'b0;
         if (lock_set) r_lock <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (rd_req) begin
                  r_slot  <= rd_slot;
                  r_busy  <= 1'b1;
                  r_state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (!w_slot_valid || r_lock) begin
                  r_rd_err <= 1'b1;
                  r_state  <= ST_ERR;
               end else begin
                  r_snap      <= w_slot_data;
                  r_cnt       <= '0;
                  r_nib_out   <= f_beat(w_slot_data, '0);
                  r_nib_valid <= 1'b1;
                  r_nib_last  <= (c_BEATS == 1);
                  r_state     <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (nib_ready) begin
                  if (r_nib_last) begin
                     r_nib_out   <= '0;
                     r_nib_valid <= 1'b0;
                     r_nib_last  <= 1'b0;
                     r_rd_done   <= 1'b1;
                     r_state     <= ST_DONE;
                  end else begin
                     r_cnt      <= w_cnt_inc;
                     r_nib_out  <= f_beat(r_snap, w_cnt_inc);
                     r_nib_last <= (w_cnt_inc == c_CNT_W'(c_BEATS - 1));
                  end
               end
            end
            ST_DONE: begin
               r_snap  <= '0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            ST_ERR: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are forced low for the whole reset window, not just after the edge.
   assign rd_busy   = r_busy & ~reset;
   assign nib_out   = reset ? '0 : r_nib_out;
   assign nib_valid = r_nib_valid & ~reset;
   assign nib_last  = r_nib_last & ~reset;
   assign rd_done   = r_rd_done & ~reset;
   assign rd_err    = r_rd_err & ~reset;

endmodule
`default_nettype wire

// File: doc/crypto_key_reader.md
CRYPTO_KEY_READER -- requirements
Module: crypto_key_reader

Interface
REQ-001 The block SHALL have these parameters:
- NUM_SLOTS, default 4, number of key slots.
- KEY_W, default 16, key width in bits.
- NIB_W, default 4, output beat width; KEY_W/NIB_W beats per key.

REQ-002 The block SHALL have these ports, clock and reset first:
- clk, input, 1, sole clock; all logic on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- key_in, input, KEY_W, key word to load.
- key_load_en, input, 1, write key_in into slot key_load_slot this cycle.
- key_load_slot, input, clog2(NUM_SLOTS), load slot index.
- lock_set, input, 1, sticky lock request; blocks all reads until reset.
- rd_req, input, 1, read request; sampled only in IDLE.
- rd_slot, input, clog2(NUM_SLOTS), read slot index; sampled with rd_req.
- rd_busy, output, 1, high in any state other than IDLE.
- nib_out, output, NIB_W, key beat data.
- nib_valid, output, 1, beat valid.
- nib_ready, input, 1, consumer accepts the beat.
- nib_last, output, 1, marks the final beat.
- rd_done, output, 1, one-cycle pulse on successful completion.
- rd_err, output, 1, one-cycle pulse on a refused read.

Function
REQ-003 Each slot SHALL have a KEY_W data register and a valid flag; key_load_en SHALL write the data and set the valid flag at the next edge.
REQ-004 The lock flag SHALL set on lock_set and SHALL clear only on reset.
REQ-005 The FSM states SHALL be IDLE, CHECK, XFER, DONE and ERR.
REQ-006 IDLE with rd_req=1 SHALL latch rd_slot and go to CHECK at the next edge; rd_req outside IDLE SHALL be ignored.
REQ-007 CHECK SHALL last one cycle:
- If the slot valid flag is 0 or the lock is set, go to ERR.
- Otherwise copy the slot into a snapshot register, load the beat counter with 0, and go to XFER.
REQ-008 A load that completes at or before the CHECK edge SHALL be visible in the snapshot; later loads SHALL NOT affect an active transfer.
REQ-009 XFER SHALL drive nib_valid=1, with nib_out equal to snapshot nibble (KEY_W/NIB_W-1-count), most significant nibble first.
REQ-010 nib_out and nib_valid SHALL hold stable until nib_ready=1; the counter SHALL advance only on nib_valid and nib_ready.
REQ-011 nib_last SHALL be high with the final beat; the accepted final beat SHALL move the FSM to DONE.
REQ-012 DONE SHALL pulse rd_done for one cycle, zero the snapshot register, and return to IDLE.
REQ-013 ERR SHALL pulse rd_err for one cycle and return to IDLE; no nib_valid SHALL occur for that request.
REQ-014 nib_out SHALL be 0 whenever nib_valid=0, so no key data appears outside XFER.
REQ-015 Minimum latency, rd_req to first nib_valid, SHALL be 2 cycles; with nib_ready held high, rd_req to rd_done SHALL be 2+KEY_W/NIB_W cycles.
REQ-016 lock_set asserted during XFER SHALL NOT abort that transfer; it SHALL block subsequent reads.
REQ-017 key_load_en and rd_req in the same cycle on the same slot SHALL make the read return the newly loaded key.

Reset
REQ-018 Reset SHALL:
- Return the FSM to IDLE.
- Clear every slot data register to 0 and every valid flag to 0.
- Clear the lock flag, the snapshot register and the beat counter.
REQ-019 While reset is high, every output SHALL be 0: nib_out, nib_valid, nib_last, rd_done, rd_err and rd_busy.
REQ-020 Reset asserted mid-transfer SHALL drop nib_valid at the next edge with no further beats; a read after reset SHALL return rd_err until the slot is reloaded.

Structure
REQ-021 A shared package crypto_key_pkg SHALL hold:
- The FSM state enum.
- The KEY_W and NIB_W defaults.
- The slot-index width function.
REQ-022 Slot storage and valid flags SHALL live in one sub-module, key_slot_bank; the FSM, snapshot and serializer SHALL stay in crypto_key_reader.

Verification
REQ-023 Load slot 2 with 16'hA5C3; rd_req slot 2; nib_ready=1 -> nib_out A,5,C,3 on consecutive cycles, nib_last on 3, rd_done one cycle later.
REQ-024 After reset, rd_req slot 1 with no prior load -> rd_err pulse 2 cycles after rd_req, nib_valid never high.
REQ-025 Load slot 0 with 16'h1234; pulse lock_set; rd_req slot 0 -> rd_err, no beats; after reset, reload and re-read -> 1,2,3,4.
REQ-026 Slot 3 holds 16'hBEEF; nib_ready low for 3 cycles on beat 1; load slot 3 with 16'h0000 during XFER -> beats B,E,E,F, each held stable while stalled.
REQ-027 Reset asserted after beat 2 of a transfer -> nib_valid=0 next cycle, rd_busy=0, and a following read of that slot -> rd_err.
